// File: rtl/life_pkg.sv
// Shared types and default geometry for the Game-of-Life sequencer.
package life_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2,
    ST_HALT = 2'd3
  } life_state_e;

  localparam int LIFE_MAP_W = 8;
  localparam int LIFE_MAP_H = 8;
  localparam int LIFE_CELLS = LIFE_MAP_W * LIFE_MAP_H;

endpackage

// File: rtl/life_tick_prescaler.sv
// Programmable down-counter producing a registered one-cycle tick every
// max(period,1) enabled cycles. Period is resampled at each reload so a
// change only takes effect from the next reload onward.
module life_tick_prescaler #(
  parameter int PERIOD_W = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                enable,
  input  logic                reload,
  input  logic [PERIOD_W-1:0] period,
  output logic                tick
);

  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] reload_val;

  // period 0 behaves like period 1: reload value is clamped to 0
  assign reload_val = (period == '0) ? '0 : period - 1'b1;

  // count down while enabled; tick is registered so it lands one cycle
  // after the counter reaches zero
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else if (reload) begin
      cnt  <= reload_val;
      tick <= 1'b0;
    end else if (enable) begin
      if (cnt == '0) begin
        cnt  <= reload_val;
        tick <= 1'b1;
      end else begin
        cnt  <= cnt - 1'b1;
        tick <= 1'b0;
      end
    end else begin
      tick <= 1'b0;
    end
  end

endmodule

// File: rtl/life_sequencer.sv
// Generation controller for the Life map register: run/pause/step/load
// sequencing, generation counting and optional auto-halt on extinction or
// still life. All outputs are registered.
module life_sequencer
  import life_pkg::*;
#(
  parameter int MAP_W     = LIFE_MAP_W,
  parameter int MAP_H     = LIFE_MAP_H,
  parameter int PERIOD_W  = 16,
  parameter int GEN_W     = 16,
  parameter bit AUTO_HALT = 1'b1
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   load,
  input  logic                   start,
  input  logic                   stop,
  input  logic                   step,
  input  logic [PERIOD_W-1:0]    period,
  input  logic [MAP_W*MAP_H-1:0] state_cur,
  input  logic [MAP_W*MAP_H-1:0] state_next,
  output logic                   map_enable,
  output logic                   init_sel,
  output logic [GEN_W-1:0]       generation,
  output logic                   running,
  output logic                   halted,
  output logic                   extinct,
  output logic                   stable
);

  life_state_e      state_q, state_d;
  logic             me_d, init_d, ext_d, stb_d;
  logic [GEN_W-1:0] gen_d;
  logic             tick, reload, advance;

  life_tick_prescaler #(.PERIOD_W(PERIOD_W)) u_presc (
    .clock  (clock),
    .reset  (reset),
    .enable (state_q == ST_RUN),
    .reload (reload),
    .period (period),
    .tick   (tick)
  );

  // next-state and next-output decode; load outranks every other command
  always_comb begin
    state_d = state_q;
    me_d    = 1'b0;
    init_d  = 1'b0;
    gen_d   = generation;
    ext_d   = extinct;
    stb_d   = stable;
    reload  = 1'b0;
    advance = 1'b0;
    if (load) begin
      state_d = ST_LOAD;
      me_d    = 1'b1;
      init_d  = 1'b1;
      gen_d   = '0;
      ext_d   = 1'b0;
      stb_d   = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_LOAD: begin
          state_d = ST_IDLE;
          if (stop) begin
            state_d = ST_IDLE;
          end else if (start) begin
            state_d = ST_RUN;
            reload  = 1'b1;
          end else if (step) begin
            advance = 1'b1;
          end
        end
        ST_RUN: begin
          // stop wins over a coincident tick, which is simply dropped
          if (stop) begin
            state_d = ST_IDLE;
          end else if (tick) begin
            if (AUTO_HALT && state_cur == '0) begin
              state_d = ST_HALT;
              ext_d   = 1'b1;
            end else if (AUTO_HALT && state_next == state_cur) begin
              state_d = ST_HALT;
              stb_d   = 1'b1;
            end else begin
              advance = 1'b1;
            end
          end
        end
        ST_HALT: begin
          if (stop) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    if (advance) begin
      me_d  = 1'b1;
      gen_d = (generation == '1) ? generation : generation + 1'b1;
    end
  end

  // state and output registers; async reset also kills any pending pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      map_enable <= 1'b0;
      init_sel   <= 1'b0;
      generation <= '0;
      extinct    <= 1'b0;
      stable     <= 1'b0;
    end else begin
      state_q    <= state_d;
      map_enable <= me_d;
      init_sel   <= init_d;
      generation <= gen_d;
      extinct    <= ext_d;
      stable     <= stb_d;
    end
  end

  assign running = (state_q == ST_RUN);
  assign halted  = (state_q == ST_HALT);

endmodule

// File: tb/tb_life_sequencer.sv
// Directed bench for life_sequencer: table-driven run/step vectors plus
// hand sequences for auto-halt, command priority, saturation and reset.
module tb_life_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        load, start, stop, step;
  logic [15:0] period;
  logic [63:0] state_cur, state_next;

  logic        me, is, run, hlt, ext, stb;
  logic [15:0] gen;
  logic        me2, is2, run2, hlt2, ext2, stb2;
  logic [2:0]  gen2;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  life_sequencer #(.GEN_W(16)) dut (
    .clock(clock), .reset(reset), .load(load), .start(start), .stop(stop),
    .step(step), .period(period), .state_cur(state_cur),
    .state_next(state_next), .map_enable(me), .init_sel(is),
    .generation(gen), .running(run), .halted(hlt), .extinct(ext),
    .stable(stb)
  );

  life_sequencer #(.GEN_W(3)) dut3 (
    .clock(clock), .reset(reset), .load(load), .start(start), .stop(stop),
    .step(step), .period(period), .state_cur(state_cur),
    .state_next(state_next), .map_enable(me2), .init_sel(is2),
    .generation(gen2), .running(run2), .halted(hlt2), .extinct(ext2),
    .stable(stb2)
  );

  typedef struct {
    logic        ld, st, sp, sx;
    logic        me, is;
    logic [15:0] gen;
    logic        run, hlt;
  } vec_t;

  vec_t vq[$];

  function automatic void add(logic ld, logic st, logic sp, logic sx,
                              logic e_me, logic e_is, logic [15:0] e_gen,
                              logic e_run, logic e_hlt);
    vec_t v;
    v.ld = ld; v.st = st; v.sp = sp; v.sx = sx;
    v.me = e_me; v.is = e_is; v.gen = e_gen; v.run = e_run; v.hlt = e_hlt;
    vq.push_back(v);
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // drive one cycle of commands, then sample just after the edge
  task automatic cyc(logic ld, logic st, logic sp, logic sx);
    load = ld; start = st; stop = sp; step = sx;
    @(posedge clock);
    #1;
    load = 0; start = 0; stop = 0; step = 0;
  endtask

  task automatic chk_zero(string nm);
    chk({nm, " main"}, {me, is, gen, run, hlt, ext, stb}, '0);
    chk({nm, " gen3"}, {me2, is2, gen2, run2, hlt2, ext2, stb2}, '0);
  endtask

  initial begin
    reset = 1'b1;
    load = 0; start = 0; stop = 0; step = 0;
    period = 16'd4; state_cur = 64'h18; state_next = 64'h24;
    repeat (2) @(posedge clock);
    #1;
    chk_zero("reset");
    @(negedge clock);
    reset = 1'b0;

    // run at period 4, then three spaced steps after a reload
    add(1, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 1; k <= 13; k++)
      add(0, 0, 0, 0, (k == 5 || k == 9 || k == 13), 0,
          (k >= 13) ? 16'd3 : (k >= 9) ? 16'd2 : (k >= 5) ? 16'd1 : 16'd0,
          1, 0);
    add(0, 0, 1, 0, 0, 0, 3, 0, 0);
    add(1, 0, 0, 0, 1, 1, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int s = 1; s <= 3; s++) begin
      add(0, 0, 0, 1, 1, 0, 16'(s), 0, 0);
      add(0, 0, 0, 0, 0, 0, 16'(s), 0, 0);
      add(0, 0, 0, 0, 0, 0, 16'(s), 0, 0);
    end
    // stop in IDLE is ignored and drops a same-cycle start
    add(0, 1, 1, 0, 0, 0, 3, 0, 0);

    foreach (vq[i]) begin
      cyc(vq[i].ld, vq[i].st, vq[i].sp, vq[i].sx);
      chk($sformatf("vec%0d me", i), me, vq[i].me);
      chk($sformatf("vec%0d init", i), is, vq[i].is);
      chk($sformatf("vec%0d gen", i), gen, vq[i].gen);
      chk($sformatf("vec%0d run", i), run, vq[i].run);
      chk($sformatf("vec%0d halt", i), hlt, vq[i].hlt);
    end

    // still life: halt with stable, stop keeps flag, load clears it
    period = 16'd1; state_cur = 64'h3C; state_next = 64'h3C;
    cyc(1, 0, 0, 0);
    chk("stb load me", me, 1);
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    chk("stb run", run, 1);
    cyc(0, 0, 0, 0);
    chk("stb edge1 me", me, 0);
    cyc(0, 0, 0, 0);
    chk("stb halted", {hlt, stb, ext, run, me}, 5'b11000);
    for (int i = 0; i < 3; i++) begin
      cyc(0, (i == 1), 0, (i == 2));
      chk("stb hold", {hlt, me, gen}, {1'b1, 1'b0, 16'd0});
    end
    cyc(0, 0, 1, 0);
    chk("stb after stop", {hlt, stb, run}, 3'b010);
    cyc(1, 0, 0, 0);
    chk("stb cleared", {stb, me, is}, 3'b011);

    // extinction wins over the equal-maps check
    state_cur = 64'h0; state_next = 64'h0;
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);
    chk("ext halted", {hlt, ext, stb, me}, 4'b1100);
    cyc(1, 0, 1, 0);
    chk("load beats stop", {me, is, ext, stb, hlt, gen}, {5'b11000, 16'd0});

    // period 0 acts as 1; narrow counter saturates while pulses continue
    period = 16'd0; state_cur = 64'h18; state_next = 64'h24;
    cyc(0, 0, 0, 0);
    cyc(0, 1, 0, 0);
    cyc(0, 0, 0, 0);
    chk("p0 edge1 me", me, 0);
    for (int i = 1; i <= 11; i++) begin
      cyc(0, 0, 0, 0);
      chk($sformatf("p0 pulse%0d", i), {me, gen}, {1'b1, 16'(i)});
      chk($sformatf("sat pulse%0d", i), {me2, gen2},
          {1'b1, (i > 7) ? 3'd7 : 3'(i)});
    end

    // asynchronous reset mid-run, pending pulse must not appear
    #2 reset = 1'b1;
    #1 chk_zero("async reset");
    @(posedge clock);
    #1 chk_zero("reset held");
    @(negedge clock);
    reset = 1'b0;
    cyc(0, 0, 0, 0);
    chk("post reset", {me, me2, run, gen}, '0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  // hard bound so the run always terminates
  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule
